// File: rtl/mem_access.sv
// rtl/mem_access.sv - Byte-serial load/store stage between EX_MEM and MEM_WB
// Ports:
//   clk_in, rst_in               clock, asynchronous active-low reset
//   instIdx_in                   instruction index from EX_MEM (6 bits)
//   memAddr_in, valStore_in      effective address and store data
//   rdE/rdIdx/rdData _in/_out    write-back request in, to MEM_WB out
//   stall_out                    holds IF..EX_MEM while a memory op runs
//   memReq/WE/Addr/Data _out     byte request to the memory controller
//   memDone_in, memData_in       byte completion pulse and read byte
module mem_access (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [5:0]  instIdx_in,
  input  logic [31:0] memAddr_in,
  input  logic [31:0] valStore_in,
  input  logic        rdE_in,
  input  logic [4:0]  rdIdx_in,
  input  logic [31:0] rdData_in,
  output logic        rdE_out,
  output logic [4:0]  rdIdx_out,
  output logic [31:0] rdData_out,
  output logic        stall_out,
  output logic        memReq_out,
  output logic        memWE_out,
  output logic [31:0] memAddr_out,
  output logic [7:0]  memData_out,
  input  logic        memDone_in,
  input  logic [7:0]  memData_in
);

  // Instruction index encodings of the memory instructions.
  localparam logic [5:0] IDX_LB  = 6'd10;
  localparam logic [5:0] IDX_LH  = 6'd11;
  localparam logic [5:0] IDX_LW  = 6'd12;
  localparam logic [5:0] IDX_LBU = 6'd13;
  localparam logic [5:0] IDX_LHU = 6'd14;
  localparam logic [5:0] IDX_SB  = 6'd15;
  localparam logic [5:0] IDX_SH  = 6'd16;
  localparam logic [5:0] IDX_SW  = 6'd17;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] load_buf_q, load_buf_d;
  logic [5:0]  op_q, op_d;

  // Number of bytes moved by an instruction; 0 marks a non-memory index.
  function automatic logic [2:0] byte_count(input logic [5:0] idx);
    case (idx)
      IDX_LB, IDX_LBU, IDX_SB: byte_count = 3'd1;
      IDX_LH, IDX_LHU, IDX_SH: byte_count = 3'd2;
      IDX_LW, IDX_SW:          byte_count = 3'd4;
      default:                 byte_count = 3'd0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] idx);
    is_store = (idx == IDX_SB) || (idx == IDX_SH) || (idx == IDX_SW);
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] idx, input logic [31:0] raw);
    case (idx)
      IDX_LB:  extend = {{24{raw[7]}}, raw[7:0]};
      IDX_LBU: extend = {24'd0, raw[7:0]};
      IDX_LH:  extend = {{16{raw[15]}}, raw[15:0]};
      IDX_LHU: extend = {16'd0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  logic in_is_mem;
  logic last_byte;

  assign in_is_mem = (byte_count(instIdx_in) != 3'd0);
  assign last_byte = ({1'b0, cnt_q} == (byte_count(op_q) - 3'd1));

  // The decoded op is latched on entry so the sequence does not depend on
  // the held EX_MEM index; address and store data are read live because
  // EX_MEM is frozen by stall_out for the whole transfer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_buf_d = load_buf_q;
    op_d       = op_q;
    case (state_q)
      S_IDLE: begin
        if (in_is_mem) begin
          state_d    = S_ACCESS;
          cnt_d      = 2'd0;
          load_buf_d = 32'd0;
          op_d       = instIdx_in;
        end
      end
      S_ACCESS: begin
        if (memDone_in) begin
          if (!is_store(op_q)) begin
            load_buf_d[{cnt_q, 3'b000} +: 8] = memData_in;
          end
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      load_buf_q <= 32'd0;
      op_q       <= 6'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_buf_q <= load_buf_d;
      op_q       <= op_d;
    end
  end

  // Outputs are gated by rst_in so that asserting reset clears them at once,
  // including the combinational pass-through path.
  always_comb begin
    rdE_out     = 1'b0;
    rdIdx_out   = 5'd0;
    rdData_out  = 32'd0;
    stall_out   = 1'b0;
    memReq_out  = 1'b0;
    memWE_out   = 1'b0;
    memAddr_out = 32'd0;
    memData_out = 8'd0;
    if (rst_in) begin
      case (state_q)
        S_IDLE: begin
          if (in_is_mem) begin
            stall_out = 1'b1;
          end else begin
            rdE_out    = rdE_in;
            rdIdx_out  = rdIdx_in;
            rdData_out = rdData_in;
          end
        end
        S_ACCESS: begin
          stall_out   = 1'b1;
          memReq_out  = 1'b1;
          memWE_out   = is_store(op_q);
          memAddr_out = memAddr_in + {30'd0, cnt_q};
          memData_out = valStore_in[{cnt_q, 3'b000} +: 8];
        end
        S_DONE: begin
          if (!is_store(op_q)) begin
            rdE_out    = rdE_in;
            rdIdx_out  = rdIdx_in;
            rdData_out = extend(op_q, load_buf_q);
          end
        end
        default: begin
          stall_out = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - Randomized self-checking bench for mem_access
module tb_mem_access;

  localparam logic [5:0] ADD = 6'd1;
  localparam logic [5:0] LB  = 6'd10;
  localparam logic [5:0] LH  = 6'd11;
  localparam logic [5:0] LW  = 6'd12;
  localparam logic [5:0] LBU = 6'd13;
  localparam logic [5:0] LHU = 6'd14;
  localparam logic [5:0] SB  = 6'd15;
  localparam logic [5:0] SH  = 6'd16;
  localparam logic [5:0] SW  = 6'd17;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [5:0]  instIdx_in;
  logic [31:0] memAddr_in, valStore_in, rdData_in;
  logic        rdE_in;
  logic [4:0]  rdIdx_in;
  logic        rdE_out, stall_out, memReq_out, memWE_out, memDone_in;
  logic [4:0]  rdIdx_out;
  logic [31:0] rdData_out, memAddr_out;
  logic [7:0]  memData_out, memData_in;

  mem_access dut (
    .clk_in(clk_in), .rst_in(rst_in), .instIdx_in(instIdx_in),
    .memAddr_in(memAddr_in), .valStore_in(valStore_in),
    .rdE_in(rdE_in), .rdIdx_in(rdIdx_in), .rdData_in(rdData_in),
    .rdE_out(rdE_out), .rdIdx_out(rdIdx_out), .rdData_out(rdData_out),
    .stall_out(stall_out), .memReq_out(memReq_out), .memWE_out(memWE_out),
    .memAddr_out(memAddr_out), .memData_out(memData_out),
    .memDone_in(memDone_in), .memData_in(memData_in)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  // Expected outputs for the current cycle, set by the stimulus.
  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_rde, exp_req, exp_we, chk_idx, chk_data;
  logic [4:0]  exp_idx;
  logic [31:0] exp_rdd, exp_addr;
  logic [7:0]  exp_mdata;

  logic [7:0]  mem [logic [31:0]];
  int          st_cnt;
  logic [31:0] cap_rdd;
  logic        cap_rde;
  logic [31:0] wlog_addr[$];
  logic [7:0]  wlog_data[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int nbytes(input logic [5:0] i);
    if (i == LB || i == LBU || i == SB) return 1;
    if (i == LH || i == LHU || i == SH) return 2;
    if (i == LW || i == SW) return 4;
    return 0;
  endfunction

  function automatic logic st_op(input logic [5:0] i);
    return (i == SB) || (i == SH) || (i == SW);
  endfunction

  function automatic logic [31:0] ext(input logic [5:0] i, input logic [31:0] v);
    if (i == LB)  return (v & 32'hFF) >= 32'h80 ? (v | 32'hFFFFFF00) : (v & 32'hFF);
    if (i == LBU) return v & 32'hFF;
    if (i == LH)  return (v & 32'hFFFF) >= 32'h8000 ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
    if (i == LHU) return v & 32'hFFFF;
    return v;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  always @(negedge clk_in) begin
    if (exp_valid && rst_in) begin
      check("stall_out", 32'(stall_out), 32'(exp_stall));
      check("rdE_out", 32'(rdE_out), 32'(exp_rde));
      check("memReq_out", 32'(memReq_out), 32'(exp_req));
      if (chk_idx) check("rdIdx_out", 32'(rdIdx_out), 32'(exp_idx));
      if (chk_data) check("rdData_out", rdData_out, exp_rdd);
      if (exp_req) begin
        check("memWE_out", 32'(memWE_out), 32'(exp_we));
        check("memAddr_out", memAddr_out, exp_addr);
        check("memData_out", 32'(memData_out), 32'(exp_mdata));
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #2;
  endtask

  task automatic sample();
    #2;
    if (stall_out) st_cnt++;
    cap_rdd = rdData_out;
    cap_rde = rdE_out;
  endtask

  // One instruction from EX_MEM. dly > 0 fixes the ACCESS cycles per byte
  // (memDone_in on the last of them); dly == 0 picks 1..3 at random.
  task automatic run_op(input logic [5:0] inst, input logic [31:0] addr, input logic [31:0] vst,
                        input logic rde, input logic [4:0] idx, input logic [31:0] rdd, input int dly);
    int n;
    int d;
    logic st;
    logic [31:0] val;
    n = nbytes(inst);
    st = st_op(inst);
    val = 32'd0;
    st_cnt = 0;
    instIdx_in = inst; memAddr_in = addr; valStore_in = vst;
    rdE_in = rde; rdIdx_in = idx; rdData_in = rdd;
    memDone_in = 1'($urandom); memData_in = 8'($urandom);
    exp_valid = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'd0; exp_mdata = 8'd0;
    if (n == 0) begin
      exp_stall = 1'b0; exp_rde = rde; exp_idx = idx; exp_rdd = rdd;
      chk_idx = 1'b1; chk_data = 1'b1;
      sample();
      cyc();
    end else begin
      exp_stall = 1'b1; exp_rde = 1'b0; chk_idx = 1'b0; chk_data = 1'b0;
      sample();
      cyc();
      for (int k = 0; k < n; k++) begin
        d = (dly > 0) ? dly : int'($urandom_range(1, 3));
        for (int j = 0; j < d; j++) begin
          exp_req = 1'b1; exp_we = st;
          exp_addr = addr + 32'(k);
          exp_mdata = 8'(vst >> (8 * k));
          memDone_in = (j == d - 1);
          if (memDone_in && !st) begin
            memData_in = mem_rd(exp_addr);
            val = val | (32'(memData_in) << (8 * k));
          end else begin
            memData_in = 8'($urandom);
          end
          sample();
          if (memDone_in && st) begin
            mem[exp_addr] = exp_mdata;
            wlog_addr.push_back(memAddr_out);
            wlog_data.push_back(memData_out);
          end
          cyc();
        end
      end
      exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0;
      memDone_in = 1'($urandom); memData_in = 8'($urandom);
      if (st) begin
        exp_rde = 1'b0; exp_rdd = 32'd0; chk_idx = 1'b0; chk_data = 1'b1;
      end else begin
        exp_rde = rde; exp_idx = idx; exp_rdd = ext(inst, val);
        chk_idx = 1'b1; chk_data = 1'b1;
      end
      sample();
      cyc();
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " rdE_out"}, 32'(rdE_out), 32'd0);
    check({nm, " rdIdx_out"}, 32'(rdIdx_out), 32'd0);
    check({nm, " rdData_out"}, rdData_out, 32'd0);
    check({nm, " stall_out"}, 32'(stall_out), 32'd0);
    check({nm, " memReq_out"}, 32'(memReq_out), 32'd0);
    check({nm, " memWE_out"}, 32'(memWE_out), 32'd0);
    check({nm, " memAddr_out"}, memAddr_out, 32'd0);
    check({nm, " memData_out"}, 32'(memData_out), 32'd0);
  endtask

  logic [5:0] pick [9] = '{ADD, LB, LH, LW, LBU, LHU, SB, SH, SW};

  initial begin
    logic [5:0] ri;
    logic [31:0] ra;
    rst_in = 1'b0;
    instIdx_in = ADD; memAddr_in = 32'h1234; valStore_in = 32'h55AA55AA;
    rdE_in = 1'b1; rdIdx_in = 5'd3; rdData_in = 32'hDEADBEEF;
    memDone_in = 1'b1; memData_in = 8'hFF;
    #3;
    check_all_zero("reset");
    @(posedge clk_in);
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;

    // ADD pass-through
    run_op(ADD, 32'h0, 32'h0, 1'b1, 5'd5, 32'h7, 0);
    check("add rdData", cap_rdd, 32'h7);
    check("add stall cycles", 32'(st_cnt), 32'd0);

    // LW 0x100 with memDone_in every cycle
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    run_op(LW, 32'h100, 32'h0, 1'b1, 5'd7, 32'h0, 1);
    check("lw data", cap_rdd, 32'h12345678);
    check("lw stall cycles", 32'(st_cnt), 32'd5);

    // Byte/half extension
    mem[32'h40] = 8'h80;
    run_op(LB, 32'h40, 32'h0, 1'b1, 5'd8, 32'h0, 1);
    check("lb data", cap_rdd, 32'hFFFFFF80);
    run_op(LBU, 32'h40, 32'h0, 1'b1, 5'd8, 32'h0, 1);
    check("lbu data", cap_rdd, 32'h00000080);
    mem[32'h50] = 8'h00; mem[32'h51] = 8'h80;
    run_op(LH, 32'h50, 32'h0, 1'b1, 5'd9, 32'h0, 1);
    check("lh data", cap_rdd, 32'hFFFF8000);
    check("lh stall cycles", 32'(st_cnt), 32'd3);

    // SH across the address wrap
    wlog_addr.delete(); wlog_data.delete();
    run_op(SH, 32'hFFFFFFFF, 32'hABCD1234, 1'b1, 5'd4, 32'h99, 1);
    check("sh writes", 32'(wlog_addr.size()), 32'd2);
    if (wlog_addr.size() == 2) begin
      check("sh addr0", wlog_addr[0], 32'hFFFFFFFF);
      check("sh data0", 32'(wlog_data[0]), 32'h34);
      check("sh addr1", wlog_addr[1], 32'h00000000);
      check("sh data1", 32'(wlog_data[1]), 32'h12);
    end
    check("sh done rdE", 32'(cap_rde), 32'd0);

    // LW with three ACCESS cycles per byte
    mem[32'h200] = 8'hEF; mem[32'h201] = 8'hBE; mem[32'h202] = 8'hAD; mem[32'h203] = 8'hDE;
    run_op(LW, 32'h200, 32'h0, 1'b1, 5'd10, 32'h0, 3);
    check("lw slow data", cap_rdd, 32'hDEADBEEF);
    check("lw slow stall cycles", 32'(st_cnt), 32'd13);

    // Reset after two LW bytes
    exp_valid = 1'b0;
    instIdx_in = LW; memAddr_in = 32'h300; rdE_in = 1'b1; rdIdx_in = 5'd2;
    memDone_in = 1'b0;
    cyc();
    memDone_in = 1'b1; memData_in = 8'h11;
    cyc();
    memData_in = 8'h22;
    cyc();
    memDone_in = 1'b0;
    #1;
    check("pre-reset memReq_out", 32'(memReq_out), 32'd1);
    check("pre-reset memAddr_out", memAddr_out, 32'h302);
    rst_in = 1'b0;
    #1;
    check_all_zero("mid-access reset");
    cyc();
    instIdx_in = ADD; rdE_in = 1'b1; rdIdx_in = 5'd9; rdData_in = 32'hCAFE;
    rst_in = 1'b1;
    #1;
    check("post-reset rdE_out", 32'(rdE_out), 32'd1);
    check("post-reset rdIdx_out", 32'(rdIdx_out), 32'd9);
    check("post-reset rdData_out", rdData_out, 32'hCAFE);
    check("post-reset memReq_out", 32'(memReq_out), 32'd0);
    check("post-reset stall_out", 32'(stall_out), 32'd0);
    cyc();
    for (int i = 0; i < 4; i++) run_op(ADD, 32'h300, 32'h0, 1'b1, 5'd9, 32'hCAFE, 0);
    run_op(LW, 32'h100, 32'h0, 1'b1, 5'd1, 32'h0, 0);
    check("lw after reset", cap_rdd, 32'h12345678);

    // Randomized back-to-back traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) ri = 6'($urandom);
      else ri = pick[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else ra = 32'($urandom_range(0, 255));
      run_op(ri, ra, $urandom, 1'($urandom), 5'($urandom), $urandom, 0);
    end

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 No parameters; widths fixed (data/address 32, register index 5, instruction index per `instIdxRange` in defines.vh).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk_in  input  1  clock; all state changes on rising edge.
REQ-004 rst_in  input  1  asynchronous active-low reset (0 = reset).
REQ-005 instIdx_in  input  `instIdxRange  instruction index from EX_MEM register.
REQ-006 memAddr_in  input  32  effective load/store address.
REQ-007 valStore_in  input  32  store data, byte 0 = bits 7:0.
REQ-008 rdE_in / rdIdx_in / rdData_in  input  1/5/32  write-back request, index, ALU result.
REQ-009 rdE_out / rdIdx_out / rdData_out  output  1/5/32  to MEM_WB register.
REQ-010 stall_out  output  1  holds IF..EX_MEM when 1; EX_MEM updates every cycle stall_out is 0.
REQ-011 memReq_out  output  1  byte request to memory controller.
REQ-012 memWE_out  output  1  1 = write byte, 0 = read byte.
REQ-013 memAddr_out  output  32  byte address of current request.
REQ-014 memData_out  output  8  write byte.
REQ-015 memDone_in  input  1  one-cycle pulse: current byte completed; read byte valid on memData_in same cycle.
REQ-016 memData_in  input  8  read byte.

Function
REQ-017 FSM states IDLE, ACCESS, DONE; byte counter cnt (2 bits); 32-bit load buffer buf.
REQ-018 Byte count n: LB/LBU/SB = 1, LH/LHU/SH = 2, LW/SW = 4; all other indices are non-memory.
REQ-019 IDLE, non-memory index: rdE_out/rdIdx_out/rdData_out = inputs combinationally, stall_out 0, memReq_out 0; stay IDLE.
REQ-020 IDLE, memory index: stall_out 1, rdE_out 0, memReq_out 0; next state ACCESS, cnt 0, buf 0.
REQ-021 ACCESS: memReq_out 1, stall_out 1, rdE_out 0; memAddr_out = memAddr_in + cnt (mod 2^32, 0xFFFFFFFF wraps to 0); memWE_out 1 for stores; memData_out = valStore_in[8*cnt+7:8*cnt].
REQ-022 ACCESS, memDone_in 1 on load: buf byte cnt <= memData_in.
REQ-023 ACCESS, memDone_in 1: if cnt == n-1 go DONE, else cnt+1 and next byte presented following cycle; memDone_in 0: hold all request outputs unchanged (no timeout).
REQ-024 DONE: stall_out 0, memReq_out 0; loads: rdE_out = rdE_in, rdIdx_out = rdIdx_in, rdData_out = extended buf; stores: rdE_out 0, rdData_out 0; next state IDLE.
REQ-025 Extension: LB sign-extends bit 7, LH bit 15, LBU/LHU zero-extend, LW unchanged.
REQ-026 Misaligned addresses SHALL be accessed byte-wise without fault.
REQ-027 memDone_in outside ACCESS SHALL be ignored.
REQ-028 Back-to-back memory ops: instruction arriving in IDLE after DONE restarts the sequence; no state carried over.
REQ-029 Latency with memDone_in every ACCESS cycle: stall_out high for n+1 cycles, result on MEM_WB inputs in DONE cycle.

Reset
REQ-030 rst_in 0 SHALL immediately force IDLE, cnt 0, buf 0, memReq_out 0, memWE_out 0, memAddr_out 0, memData_out 0, stall_out 0, rdE_out 0, rdIdx_out 0, rdData_out 0.
REQ-031 Reset mid-ACCESS SHALL abandon the transfer; no further request issued until a new memory index is seen after release.

Verification
REQ-032 LW addr 0x100, memory 0x78,0x56,0x34,0x12, memDone_in every cycle -> reads 0x100..0x103, stall_out 5 cycles, DONE rdData_out 0x12345678.
REQ-033 LB addr 0x40 byte 0x80 -> rdData_out 0xFFFFFF80; LBU same -> 0x00000080; LH bytes 0x00,0x80 -> 0xFFFF8000.
REQ-034 SH addr 0xFFFFFFFF valStore 0xABCD1234 -> write 0x34 @0xFFFFFFFF, 0x12 @0x00000000, rdE_out 0 in DONE.
REQ-035 ADD rdIdx 5 rdData 0x7 -> same-cycle pass-through, stall_out 0, memReq_out 0.
REQ-036 LW with memDone_in delayed 3 cycles per byte -> request outputs stable while waiting, stall_out 13 cycles, correct data.
REQ-037 rst_in low after 2 LW bytes -> all outputs 0 asynchronously; after release with ADD present, pass-through, no memReq_out.
